voice_allocator: RTL and testbench

- Polyphonic voice allocator that shares a bank of VOICES nco instances between incoming note events.
- Accepts note-on/note-off strobes carrying a 7-bit note number and drives a per-voice NOTE_NUM bus, gate vector and retrigger pulses.
- Sits between the MIDI decoder and the nco bank.
- When all voices are busy, steals the least-recently-assigned voice.

---
 rtl/voice_allocator.sv | 222 ++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice allocator for an nco bank.
// Scans the voices one per cycle after each accepted note event, then
// commits a retrigger / free-voice assignment / oldest-voice steal
// (note-on) or a gate release (note-off).
// Optional feature macro: VOICE_ALLOC_SUSTAIN_EN (adds SUSTAIN input and
// sustain-pedal hold/release of note-offs).
module voice_allocator #(
   parameter int VOICES = 4,
   parameter int RANK_W = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  NOTE_ON,
   input  logic                  NOTE_OFF,
   input  logic [6:0]            NOTE_IN,
`ifdef VOICE_ALLOC_SUSTAIN_EN
   input  logic                  SUSTAIN,
`endif
   output logic                  READY,
   output logic [7*VOICES-1:0]   VOICE_NOTES,
   output logic [VOICES-1:0]     VOICE_GATE,
   output logic [VOICES-1:0]     VOICE_TRIG,
   output logic                  STEAL
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      COMMIT  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [RANK_W-1:0] LAST = RANK_W'(VOICES - 1);

   state_t             state_q;
   logic [RANK_W-1:0]  idx_q;
   logic [6:0]         note_lat_q;
   logic               off_q;
   logic               match_vld_q;
   logic [RANK_W-1:0]  match_idx_q;
   logic               free_vld_q;
   logic [RANK_W-1:0]  free_idx_q;
   logic [RANK_W-1:0]  old_idx_q;
   logic [6:0]         notes_q [VOICES];
   logic [RANK_W-1:0]  rank_q  [VOICES];
   logic [VOICES-1:0]  gate_q;
   logic [VOICES-1:0]  trig_q;
   logic               steal_q;
   logic               ready_q;
`ifdef VOICE_ALLOC_SUSTAIN_EN
   logic [VOICES-1:0]  sus_q;
   logic               sus_prev_q;
   logic               pend_q;
`endif

   logic [RANK_W-1:0]  target_d;
   logic               steal_d;
   logic [RANK_W-1:0]  rank_d [VOICES];
   logic               match_hit_d;
   logic               free_hit_d;
   logic               old_hit_d;

   // Per-cycle scan tests on the voice currently indexed by idx_q.
   always_comb begin
      match_hit_d = gate_q[idx_q] && (notes_q[idx_q] == note_lat_q);
      free_hit_d  = !gate_q[idx_q];
      old_hit_d   = (rank_q[idx_q] == LAST);
   end

   // Note-on target selection by priority and the resulting rank update.
   always_comb begin
      target_d = old_idx_q;
      steal_d  = 1'b1;
      if (match_vld_q) begin
         target_d = match_idx_q;
         steal_d  = 1'b0;
      end else if (free_vld_q) begin
         target_d = free_idx_q;
         steal_d  = 1'b0;
      end
      for (int unsigned i = 0; i < VOICES; i++) begin
         rank_d[i] = rank_q[i];
         if (RANK_W'(i) == target_d) begin
            rank_d[i] = '0;
         end else if (rank_q[i] < rank_q[target_d]) begin
            rank_d[i] = rank_q[i] + 1'b1;
         end
      end
   end

   // Allocator FSM with registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         note_lat_q  <= '0;
         off_q       <= 1'b0;
         match_vld_q <= 1'b0;
         match_idx_q <= '0;
         free_vld_q  <= 1'b0;
         free_idx_q  <= '0;
         old_idx_q   <= '0;
         gate_q      <= '0;
         trig_q      <= '0;
         steal_q     <= 1'b0;
         ready_q     <= 1'b1;
         for (int unsigned i = 0; i < VOICES; i++) begin
            notes_q[i] <= '0;
            rank_q[i]  <= RANK_W'(i);
         end
`ifdef VOICE_ALLOC_SUSTAIN_EN
         sus_q      <= '0;
         sus_prev_q <= 1'b0;
         pend_q     <= 1'b0;
`endif
      end else begin
         trig_q  <= '0;
         steal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (NOTE_ON || NOTE_OFF) begin
                  note_lat_q  <= NOTE_IN;
                  off_q       <= NOTE_OFF;
                  ready_q     <= 1'b0;
                  idx_q       <= '0;
                  match_vld_q <= 1'b0;
                  free_vld_q  <= 1'b0;
                  old_idx_q   <= '0;
                  state_q     <= SCAN;
               end
`ifdef VOICE_ALLOC_SUSTAIN_EN
               else if (pend_q) begin
                  for (int unsigned i = 0; i < VOICES; i++) begin
                     if (sus_q[i]) begin
                        gate_q[i] <= 1'b0;
                     end
                  end
                  sus_q   <= '0;
                  pend_q  <= 1'b0;
                  ready_q <= 1'b0;
                  state_q <= RELEASE;
               end
`endif
            end
            SCAN: begin
               if (!match_vld_q && match_hit_d) begin
                  match_vld_q <= 1'b1;
                  match_idx_q <= idx_q;
               end
               if (!free_vld_q && free_hit_d) begin
                  free_vld_q <= 1'b1;
                  free_idx_q <= idx_q;
               end
               if (old_hit_d) begin
                  old_idx_q <= idx_q;
               end
               if (idx_q == LAST) begin
                  state_q <= COMMIT;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            COMMIT: begin
               if (!off_q) begin
                  notes_q[target_d] <= note_lat_q;
                  gate_q[target_d]  <= 1'b1;
                  trig_q[target_d]  <= 1'b1;
                  steal_q           <= steal_d;
                  for (int unsigned i = 0; i < VOICES; i++) begin
                     rank_q[i] <= rank_d[i];
                  end
`ifdef VOICE_ALLOC_SUSTAIN_EN
                  sus_q[target_d] <= 1'b0;
`endif
               end else if (match_vld_q) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                  if (SUSTAIN) begin
                     sus_q[match_idx_q] <= 1'b1;
                  end else begin
                     gate_q[match_idx_q] <= 1'b0;
                  end
`else
                  gate_q[match_idx_q] <= 1'b0;
`endif
               end
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            RELEASE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
`ifdef VOICE_ALLOC_SUSTAIN_EN
         // Pedal falling edge is recorded last so a new release request
         // survives a release being serviced on the same edge.
         sus_prev_q <= SUSTAIN;
         if (sus_prev_q && !SUSTAIN) begin
            pend_q <= 1'b1;
         end
`endif
      end
   end

   // Output packing of the per-voice note registers.
   always_comb begin
      VOICE_NOTES = '0;
      for (int unsigned i = 0; i < VOICES; i++) begin
         VOICE_NOTES[7*i +: 7] = notes_q[i];
      end
   end

   assign READY      = ready_q;
   assign VOICE_GATE = gate_q;
   assign VOICE_TRIG = trig_q;
   assign STEAL      = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator (VOICES=4): directed note events, a
// queue-based LRU allocation model compared on every cycle, plus literal
// expectations for the scenarios of interest.
module tb_voice_allocator;

   localparam int V = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             NOTE_ON = 1'b0;
   logic             NOTE_OFF = 1'b0;
   logic [6:0]       NOTE_IN = '0;
   logic             SUSTAIN = 1'b0;
   logic             READY;
   logic [7*V-1:0]   VOICE_NOTES;
   logic [V-1:0]     VOICE_GATE;
   logic [V-1:0]     VOICE_TRIG;
   logic             STEAL;

   int checks = 0;
   int errors = 0;

   voice_allocator #(.VOICES(V), .RANK_W(2)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .NOTE_ON     (NOTE_ON),
      .NOTE_OFF    (NOTE_OFF),
      .NOTE_IN     (NOTE_IN),
`ifdef VOICE_ALLOC_SUSTAIN_EN
      .SUSTAIN     (SUSTAIN),
`endif
      .READY       (READY),
      .VOICE_NOTES (VOICE_NOTES),
      .VOICE_GATE  (VOICE_GATE),
      .VOICE_TRIG  (VOICE_TRIG),
      .STEAL       (STEAL)
   );

   always #5 CLK = ~CLK;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   int         m_note [V];
   bit         m_gate [V];
   bit         m_sus  [V];
   int         lru [$];          // most recently assigned first
   bit         m_ready;
   int         m_cnt;
   bit         m_rel, m_pend, m_susprev;
   logic [6:0] m_lat;
   bit         m_off;
   logic [V-1:0] m_trig;
   bit         m_steal;

   function automatic void model_reset();
      lru.delete();
      for (int i = 0; i < V; i++) begin
         m_note[i] = 0; m_gate[i] = 0; m_sus[i] = 0;
         lru.push_back(i);
      end
      m_ready = 1; m_cnt = 0; m_rel = 0; m_pend = 0; m_susprev = 0;
      m_trig = '0; m_steal = 0; m_lat = '0; m_off = 0;
   endfunction

   function automatic int find_match(int n);
      for (int i = 0; i < V; i++)
         if (m_gate[i] && m_note[i] == n) return i;
      return -1;
   endfunction

   function automatic void model_apply(bit sus_now);
      int t;
      bit stl;
      t = find_match(int'(m_lat));
      if (!m_off) begin
         stl = 0;
         if (t < 0)
            for (int i = 0; i < V; i++)
               if (!m_gate[i] && t < 0) t = i;
         if (t < 0) begin
            t = lru[lru.size()-1];
            stl = 1;
         end
         m_note[t] = int'(m_lat);
         m_gate[t] = 1;
         m_sus[t]  = 0;
         m_trig    = '0;
         m_trig[t] = 1'b1;
         m_steal   = stl;
         for (int i = 0; i < lru.size(); i++)
            if (lru[i] == t) begin lru.delete(i); break; end
         lru.push_front(t);
      end else if (t >= 0) begin
         if (sus_now) m_sus[t] = 1;
         else         m_gate[t] = 0;
      end
   endfunction

   function automatic void model_step();
      bit sus_now;
      bit fall;
      sus_now = 0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      sus_now = SUSTAIN;
`endif
      fall = m_susprev && !sus_now;
      m_trig = '0;
      m_steal = 0;
      if (m_ready) begin
         if (NOTE_ON || NOTE_OFF) begin
            m_lat = NOTE_IN; m_off = NOTE_OFF; m_cnt = V + 1; m_ready = 0;
         end else if (m_pend) begin
            for (int i = 0; i < V; i++) begin
               if (m_sus[i]) m_gate[i] = 0;
               m_sus[i] = 0;
            end
            m_pend = 0; m_ready = 0; m_rel = 1;
         end
      end else if (m_rel) begin
         m_rel = 0; m_ready = 1;
      end else begin
         m_cnt--;
         if (m_cnt == 0) begin
            model_apply(sus_now);
            m_ready = 1;
         end
      end
      if (fall) m_pend = 1;
      m_susprev = sus_now;
   endfunction

   initial forever begin
      @(posedge CLK or posedge RST);
      if (RST) model_reset();
      else     model_step();
   end

   function automatic logic [V-1:0] gate_vec();
      logic [V-1:0] g;
      for (int i = 0; i < V; i++) g[i] = m_gate[i];
      return g;
   endfunction

   function automatic logic [7*V-1:0] notes_vec();
      logic [7*V-1:0] n;
      for (int i = 0; i < V; i++) n[7*i +: 7] = 7'(m_note[i]);
      return n;
   endfunction

   // Cycle-by-cycle comparison against the model.
   initial forever begin
      @(negedge CLK);
      chk("cyc_ready", READY, m_ready);
      chk("cyc_gate", VOICE_GATE, gate_vec());
      chk("cyc_notes", VOICE_NOTES, notes_vec());
      chk("cyc_trig", VOICE_TRIG, m_trig);
      chk("cyc_steal", STEAL, m_steal);
   end

   // ---------------- stimulus ----------------
   logic [V-1:0] trig_s;
   logic         steal_s;

   task automatic do_reset();
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK); RST = 1'b0;
   endtask

   task automatic ev(input logic on, input logic off, input logic [6:0] n, input bit poke,
                     output logic [V-1:0] trig, output logic stl);
      int lowcnt;
      @(negedge CLK);
      NOTE_ON = on; NOTE_OFF = off; NOTE_IN = n;
      @(negedge CLK);
      NOTE_ON = 1'b0; NOTE_OFF = 1'b0;
      lowcnt = 0;
      while (!READY && lowcnt < 20) begin
         lowcnt++;
         if (poke && lowcnt == 1) begin NOTE_ON = 1'b1; NOTE_IN = 7'd71; end
         if (poke && lowcnt == 2) begin NOTE_ON = 1'b0; end
         @(negedge CLK);
      end
      chk("ready_low_cycles", lowcnt, V + 1);
      trig = VOICE_TRIG;
      stl  = STEAL;
   endtask

   initial begin
      // reset state
      do_reset();
      @(negedge CLK);
      chk("rst_ready", READY, 1);
      chk("rst_gate", VOICE_GATE, 0);
      chk("rst_notes", VOICE_NOTES, 0);
      chk("model_rst_oldest", lru[V-1], V - 1);

      // single note-on
      ev(1, 0, 7'd60, 0, trig_s, steal_s);
      chk("on60_trig", trig_s, 4'b0001);
      chk("on60_steal", steal_s, 0);
      chk("on60_gate", VOICE_GATE, 4'b0001);
      chk("on60_v0", VOICE_NOTES[6:0], 60);
      @(negedge CLK);
      chk("on60_trig_gone", VOICE_TRIG, 0);

      // fill all voices then steal oldest
      do_reset();
      ev(1, 0, 7'd60, 0, trig_s, steal_s);
      ev(1, 0, 7'd62, 0, trig_s, steal_s);
      ev(1, 0, 7'd64, 0, trig_s, steal_s);
      ev(1, 0, 7'd67, 0, trig_s, steal_s);
      chk("fill_trig3", trig_s, 4'b1000);
      chk("fill_notes", VOICE_NOTES, {7'd67, 7'd64, 7'd62, 7'd60});
      ev(1, 0, 7'd72, 0, trig_s, steal_s);
      chk("steal_trig", trig_s, 4'b0001);
      chk("steal_flag", steal_s, 1);
      chk("steal_gate", VOICE_GATE, 4'b1111);
      chk("steal_notes", VOICE_NOTES, {7'd67, 7'd64, 7'd62, 7'd72});
      chk("model_steal_v0", m_note[0], 72);
      ev(1, 0, 7'd74, 0, trig_s, steal_s);
      chk("steal2_trig", trig_s, 4'b0010);
      chk("steal2_flag", steal_s, 1);

      // retrigger
      do_reset();
      ev(1, 0, 7'd60, 0, trig_s, steal_s);
      ev(1, 0, 7'd60, 0, trig_s, steal_s);
      chk("retrig_trig", trig_s, 4'b0001);
      chk("retrig_steal", steal_s, 0);
      chk("retrig_gate", VOICE_GATE, 4'b0001);
      chk("retrig_v1", VOICE_NOTES[13:7], 0);

      // note-off handling
      do_reset();
      ev(1, 0, 7'd60, 0, trig_s, steal_s);
      ev(1, 0, 7'd62, 0, trig_s, steal_s);
      ev(0, 1, 7'd60, 0, trig_s, steal_s);
      chk("off60_gate", VOICE_GATE, 4'b0010);
      chk("off60_v0", VOICE_NOTES[6:0], 60);
      chk("off60_trig", trig_s, 0);
      ev(0, 1, 7'd50, 0, trig_s, steal_s);
      chk("off50_gate", VOICE_GATE, 4'b0010);
      ev(1, 0, 7'd64, 0, trig_s, steal_s);
      chk("on64_trig", trig_s, 4'b0001);
      chk("on64_gate", VOICE_GATE, 4'b0011);
      chk("on64_v0", VOICE_NOTES[6:0], 64);

      // both strobes: treated as note-off
      ev(1, 1, 7'd62, 0, trig_s, steal_s);
      chk("both_gate", VOICE_GATE, 4'b0001);
      chk("both_trig", trig_s, 0);

      // strobe while busy is dropped
      ev(1, 0, 7'd70, 1, trig_s, steal_s);
      chk("drop_trig", trig_s, 4'b0010);
      chk("drop_gate", VOICE_GATE, 4'b0011);
      chk("drop_v1", VOICE_NOTES[13:7], 70);
      chk("drop_v2", VOICE_NOTES[20:14], 0);
      repeat (8) @(negedge CLK);
      chk("drop_gate_late", VOICE_GATE, 4'b0011);

      // note 0 is a valid note
      ev(1, 0, 7'd0, 0, trig_s, steal_s);
      chk("note0_trig", trig_s, 4'b0100);
      chk("note0_gate", VOICE_GATE, 4'b0111);

      // reset mid-scan
      @(negedge CLK);
      NOTE_ON = 1'b1; NOTE_IN = 7'd80;
      @(negedge CLK);
      NOTE_ON = 1'b0;
      @(negedge CLK);
      chk("midscan_busy", READY, 0);
      #2 RST = 1'b1;
      #1;
      chk("midscan_rst_gate", VOICE_GATE, 0);
      chk("midscan_rst_notes", VOICE_NOTES, 0);
      chk("midscan_rst_trig", VOICE_TRIG, 0);
      chk("midscan_rst_ready", READY, 1);
      @(negedge CLK); RST = 1'b0;
      repeat (8) @(negedge CLK);
      chk("midscan_after_gate", VOICE_GATE, 0);

`ifdef VOICE_ALLOC_SUSTAIN_EN
      // sustain pedal holds a released note until the pedal lifts
      do_reset();
      @(negedge CLK); SUSTAIN = 1'b1;
      ev(1, 0, 7'd60, 0, trig_s, steal_s);
      ev(0, 1, 7'd60, 0, trig_s, steal_s);
      chk("sus_hold_gate", VOICE_GATE, 4'b0001);
      @(negedge CLK); SUSTAIN = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("sus_release_gate", VOICE_GATE, 0);
      repeat (3) @(negedge CLK);
`endif

      repeat (2) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
